// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Single-port RAM arbiter for instruction fetch and data
//                accesses. Data has priority over fetch. A ready-based RAM
//                handshake is used. The block also provides sticky halt
//                tracking, a ram_ready timeout watchdog and per-source
//                completion counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [31:0]       iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [31:0]       daddr,
  input  logic [31:0]       dstore,
  input  logic              halt,
  output logic              ihit,
  output logic              dhit,
  output logic [31:0]       iload,
  output logic [31:0]       dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [31:0]       ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic              ram_ready,
  output logic              halted,
  output logic              mem_err,
  output logic [CNT_W-1:0]  icount,
  output logic [CNT_W-1:0]  dcount
);

  // Wait counter is wide enough to hold TIMEOUT itself.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state;
  logic              halt_seen;
  logic              halt_seen_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  // Byte-offset bits are dropped: the RAM is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

  // Halt is sticky; the value after the current edge decides `halted`.
  assign halt_seen_nxt = halt_seen | halt;

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      halt_seen <= 1'b0;
      wait_cnt  <= '0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      iload     <= '0;
      dload     <= '0;
      ramREN    <= 1'b0;
      ramWEN    <= 1'b0;
      ramaddr   <= '0;
      ramstore  <= '0;
      halted    <= 1'b0;
      mem_err   <= 1'b0;
      icount    <= '0;
      dcount    <= '0;
    end else begin
      halt_seen <= halt_seen_nxt;
      // Hits are single-cycle strobes; only the RAM-completion edge raises them.
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            // A simultaneous read+write request is treated as a write.
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= {daddr[31:2], 2'b00};
            ramstore <= dWEN ? dstore : 32'd0;
            wait_cnt <= WAIT_W'(1);
            halted   <= 1'b0;
            state    <= DACC;
          end else if (iREN && !halt_seen) begin
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= {iaddr[31:2], 2'b00};
            ramstore <= 32'd0;
            wait_cnt <= WAIT_W'(1);
            halted   <= 1'b0;
            state    <= IACC;
          end else begin
            halted   <= halt_seen_nxt;
          end
        end
        DACC, IACC: begin
          if (ram_ready) begin
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            wait_cnt <= '0;
            state    <= RESP;
            if (state == DACC) begin
              dhit   <= 1'b1;
              dload  <= ramWEN ? 32'd0 : ramload;
              dcount <= dcount + CNT_W'(1);
            end else begin
              ihit   <= 1'b1;
              iload  <= ramload;
              icount <= icount + CNT_W'(1);
            end
          end else if (wait_cnt == TIMEOUT_CNT) begin
            // wait_cnt counts enabled cycles, so the RAM gets exactly TIMEOUT of them.
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            mem_err  <= 1'b1;
            state    <= ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RESP: begin
          // One dead cycle lets the requester drop its request before re-arbitration.
          halted <= halt_seen_nxt;
          state  <= IDLE;
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench for memory_arbiter. The bench plays both
//                the CPU requester and the RAM, with a transaction-level
//                expectation of latency, priority, counters and loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  localparam int TIMEOUT = 6;
  localparam int CNT_W   = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             iREN, dREN, dWEN, halt, ram_ready;
  logic [31:0]      iaddr, daddr, dstore, ramload;
  logic             ihit, dhit, ramREN, ramWEN, halted, mem_err;
  logic [31:0]      iload, dload, ramaddr, ramstore;
  logic [CNT_W-1:0] icount, dcount;

  int errors = 0;
  int checks = 0;

  // Reference state: completions since reset and last delivered loads.
  int          exp_icount = 0;
  int          exp_dcount = 0;
  logic [31:0] exp_iload  = '0;
  logic [31:0] exp_dload  = '0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .halt(halt),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .halted(halted), .mem_err(mem_err),
    .icount(icount), .dcount(dcount)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; halt = 0; ram_ready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 0;
    step();
    nRST = 1;
    exp_icount = 0; exp_dcount = 0;
    exp_iload = '0; exp_dload = '0;
  endtask

  // Plays the RAM for one access. gap = cycles from now until the enable must
  // appear; lat = enabled cycles until ram_ready is returned. The hit must
  // follow in the next cycle. The served request is dropped on its hit.
  task automatic run_access(input bit is_data, input bit wr,
                            input logic [31:0] addr, input logic [31:0] store,
                            input int gap, input int lat,
                            input logic [31:0] rdata, input bit drop_early,
                            input string tag);
    logic [31:0] exp_addr;
    logic [31:0] exp_store;
    exp_addr  = {addr[31:2], 2'b00};
    exp_store = wr ? store : 32'd0;
    for (int i = 1; i <= gap; i++) begin
      step();
      if (i < gap) begin
        checks++;
        if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin
          errors++;
          $display("FAIL %s idle_gap: ren/wen/ihit/dhit=%b required 0000", tag, {ramREN, ramWEN, ihit, dhit});
        end
      end
    end
    checks++;
    if ({ramREN, ramWEN} !== {~wr, wr}) begin
      errors++;
      $display("FAIL %s enables: ren/wen=%b required %b", tag, {ramREN, ramWEN}, {~wr, wr});
    end
    checks++;
    if (ramaddr !== exp_addr) begin
      errors++;
      $display("FAIL %s ramaddr: got %h required %h", tag, ramaddr, exp_addr);
    end
    checks++;
    if (ramstore !== exp_store) begin
      errors++;
      $display("FAIL %s ramstore: got %h required %h", tag, ramstore, exp_store);
    end
    if (drop_early) begin
      if (is_data) begin dREN = 0; dWEN = 0; end
      else iREN = 0;
    end
    for (int j = 1; j <= lat; j++) begin
      if (j > 1) begin
        checks++;
        if ({ramREN, ramWEN, ihit, dhit} !== {~wr, wr, 2'b00}) begin
          errors++;
          $display("FAIL %s wait_%0d: ren/wen/ihit/dhit=%b required %b", tag, j, {ramREN, ramWEN, ihit, dhit}, {~wr, wr, 2'b00});
        end
      end
      ram_ready = (j == lat);
      ramload   = (j == lat) ? rdata : $urandom;
      step();
    end
    ram_ready = 0;
    ramload   = $urandom;
    if (is_data) begin
      exp_dcount++;
      exp_dload = wr ? 32'd0 : rdata;
    end else begin
      exp_icount++;
      exp_iload = rdata;
    end
    checks++;
    if ({ihit, dhit, ramREN, ramWEN} !== {~is_data, is_data, 2'b00}) begin
      errors++;
      $display("FAIL %s hit: ihit/dhit/ren/wen=%b required %b", tag, {ihit, dhit, ramREN, ramWEN}, {~is_data, is_data, 2'b00});
    end
    checks++;
    if (is_data ? (dload !== exp_dload) : (iload !== exp_iload)) begin
      errors++;
      $display("FAIL %s load: got %h required %h", tag, is_data ? dload : iload, is_data ? exp_dload : exp_iload);
    end
    checks++;
    if (32'(icount) !== 32'(exp_icount % (1 << CNT_W)) || 32'(dcount) !== 32'(exp_dcount % (1 << CNT_W))) begin
      errors++;
      $display("FAIL %s counters: icount=%0d dcount=%0d required %0d %0d", tag, icount, dcount,
               exp_icount % (1 << CNT_W), exp_dcount % (1 << CNT_W));
    end
    if (is_data) begin dREN = 0; dWEN = 0; end
    else iREN = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 0;
    step();
    step();
    checks++;
    if ({ihit, dhit, ramREN, ramWEN, halted, mem_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000", {ihit, dhit, ramREN, ramWEN, halted, mem_err});
    end
    checks++;
    if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: iload=%h dload=%h ramaddr=%h ramstore=%h required 0", iload, dload, ramaddr, ramstore);
    end
    checks++;
    if ({icount, dcount} !== '0) begin
      errors++;
      $display("FAIL reset_counts: icount=%0d dcount=%0d required 0", icount, dcount);
    end
    nRST = 1;
    exp_icount = 0; exp_dcount = 0; exp_iload = '0; exp_dload = '0;
  endtask

  task automatic test_fetch();
    do_reset();
    iREN = 1; iaddr = 32'h40;
    run_access(0, 0, 32'h40, 32'd0, 1, 1, 32'h8C220004, 0, "fetch");
    step();
    checks++;
    if (ihit !== 1'b0 || iload !== 32'h8C220004) begin
      errors++;
      $display("FAIL fetch_hold: ihit=%b iload=%h required 0 8c220004", ihit, iload);
    end
  endtask

  task automatic test_priority();
    do_reset();
    iREN = 1; iaddr = 32'h80;
    dWEN = 1; daddr = 32'h103; dstore = 32'hDEADBEEF;
    run_access(1, 1, 32'h103, 32'hDEADBEEF, 1, 1, 32'h0, 0, "prio_write");
    run_access(0, 0, 32'h80, 32'd0, 2, 1, 32'h11223344, 0, "prio_fetch");
  endtask

  task automatic test_rw_both();
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h208; dstore = 32'hCAFEF00D;
    run_access(1, 1, 32'h208, 32'hCAFEF00D, 1, 2, 32'h12345678, 0, "rw_both");
  endtask

  task automatic test_slow_read();
    do_reset();
    dREN = 1; daddr = 32'h2006;
    run_access(1, 0, 32'h2006, 32'd0, 1, 5, 32'hA5A5_5A5A, 0, "slow_read");
    step();
    checks++;
    if (dhit !== 1'b0 || dload !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL slow_read_once: dhit=%b dload=%h required 0 a5a55a5a", dhit, dload);
    end
  endtask

  // Back-to-back random transactions; counters wrap at 2^CNT_W.
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int          kind;
      bit          also_fetch, drop;
      int          lat;
      logic [31:0] a_d, a_i, st, rd_d, rd_i;
      kind = $urandom_range(0, 3);
      also_fetch = $urandom_range(0, 1);
      drop = $urandom_range(0, 1);
      lat = $urandom_range(1, 5);
      a_d = $urandom; a_i = $urandom; st = $urandom; rd_d = $urandom; rd_i = $urandom;
      if (kind == 0) begin
        iREN = 1; iaddr = a_i;
        run_access(0, 0, a_i, 32'd0, 1, lat, rd_i, drop, "rand_fetch");
      end else begin
        dREN = (kind != 2); dWEN = (kind != 1); daddr = a_d; dstore = st;
        iREN = also_fetch; iaddr = a_i;
        run_access(1, kind != 1, a_d, st, 1, lat, rd_d, drop, "rand_data");
        if (also_fetch)
          run_access(0, 0, a_i, 32'd0, 2, $urandom_range(1, 5), rd_i, 0, "rand_fetch2");
      end
      step();
      checks++;
      if ({ihit, dhit} !== 2'b00 || iload !== exp_iload || dload !== exp_dload) begin
        errors++;
        $display("FAIL rand_hold: ihit/dhit=%b iload=%h dload=%h required 00 %h %h", {ihit, dhit}, iload, dload, exp_iload, exp_dload);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    dREN = 1; daddr = 32'h500;
    step();
    checks++;
    if (ramREN !== 1'b1) begin
      errors++;
      $display("FAIL halt_read_start: ramREN=%b required 1", ramREN);
    end
    halt = 1;
    step();
    halt = 0;
    ram_ready = 1; ramload = 32'h0BADCAFE;
    step();
    ram_ready = 0;
    checks++;
    if (dhit !== 1'b1 || dload !== 32'h0BADCAFE) begin
      errors++;
      $display("FAIL halt_read_done: dhit=%b dload=%h required 1 0badcafe", dhit, dload);
    end
    dREN = 0; iREN = 1; iaddr = 32'h44;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (halted !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0) begin
        errors++;
        $display("FAIL halt_no_fetch: halted=%b ramREN=%b ihit=%b required 1 0 0", halted, ramREN, ihit);
      end
      step();
    end
    exp_dcount = 1;
    dWEN = 1; daddr = 32'h504; dstore = 32'h77;
    run_access(1, 1, 32'h504, 32'h77, 1, 2, 32'h0, 0, "halt_write");
    step();
    step();
    checks++;
    if (halted !== 1'b1 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL halt_after_write: halted=%b ramREN=%b required 1 0", halted, ramREN);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    iREN = 1; iaddr = 32'h60;
    run_access(0, 0, 32'h60, 32'd0, 1, 1, 32'h1, 0, "pre_reset");
    step();
    iREN = 1;
    step();
    checks++;
    if (ramREN !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_start: ramREN=%b required 1", ramREN);
    end
    nRST = 0; ram_ready = 1; ramload = 32'hFFFF0000;
    step();
    ram_ready = 0;
    checks++;
    if ({ihit, ramREN, ramWEN} !== 3'b000 || {icount, dcount} !== '0) begin
      errors++;
      $display("FAIL mid_reset: ihit/ren/wen=%b icount=%0d dcount=%0d required 000 0 0", {ihit, ramREN, ramWEN}, icount, dcount);
    end
    nRST = 1;
    exp_icount = 0; exp_dcount = 0; exp_iload = '0; exp_dload = '0;
    run_access(0, 0, 32'h60, 32'd0, 1, 2, 32'h2468ACE0, 0, "restart");
  endtask

  task automatic test_timeout();
    do_reset();
    dREN = 1; daddr = 32'h700;
    for (int i = 1; i <= TIMEOUT; i++) begin
      step();
      checks++;
      if (ramREN !== 1'b1 || mem_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait_%0d: ramREN=%b mem_err=%b required 1 0", i, ramREN, mem_err);
      end
    end
    step();
    checks++;
    if (mem_err !== 1'b1 || {ramREN, ramWEN} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_err: mem_err=%b ren/wen=%b required 1 00", mem_err, {ramREN, ramWEN});
    end
    dREN = 0; iREN = 1; dWEN = 1; ram_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000 || mem_err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky: ren/wen/ihit/dhit=%b mem_err=%b required 0000 1", {ramREN, ramWEN, ihit, dhit}, mem_err);
      end
    end
    clear_inputs();
    nRST = 0;
    step();
    nRST = 1;
    checks++;
    if (mem_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: mem_err=%b required 0", mem_err);
    end
  endtask

  initial begin
    clear_inputs();
    nRST = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_rw_both();
    test_slow_read();
    test_random();
    test_halt();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Memory-side responder for the CPU's imemREN/dREN/dWEN requests; returns the ihit/dhit strobes and load data that the control unit consumes.
- Arbitrates instruction and data requests onto one single-port RAM through a ready-based handshake.
- Data has priority over instruction fetch.
- Also provides halt handling, a RAM timeout watchdog and access counters.
- Sits between datapath/request unit and RAM.

Parameters:
- TIMEOUT, 255: max cycles an access waits for ram_ready before entering ERR.
- CNT_W, 32: width of the access counters.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  synchronous active-low reset
- iREN  input  1  instruction fetch request (imemREN from control unit)
- iaddr  input  32  fetch address
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  32  data address
- dstore  input  32  write data
- halt  input  1  CPU halt indication
- ihit  output  1  one-cycle fetch complete strobe
- dhit  output  1  one-cycle data complete strobe
- iload  output  32  fetched instruction, valid while ihit=1
- dload  output  32  read data, valid while dhit=1 for reads
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM word address, bits [1:0] forced 0
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid when ram_ready=1
- ram_ready  input  1  RAM access complete, sampled at the rising edge
- halted  output  1  sticky: halt seen and no access outstanding
- mem_err  output  1  sticky timeout error
- icount  output  CNT_W  completed fetches
- dcount  output  CNT_W  completed data accesses

Behaviour:
- All state is registered. Reset (nRST=0 at an edge) drives every output to 0 and the state to IDLE. This holds mid-access: ramREN/ramWEN are low in the cycle after the reset edge, and a pending hit is never issued.
- States: IDLE, DACC, IACC, RESP, ERR.
- IDLE, data request (dREN|dWEN): latch daddr, dstore and op, then go to DACC. If dREN and dWEN are both 1, the write is performed and dload is 0.
- IDLE, otherwise: if iREN=1 and halt_seen=0, latch iaddr and go to IACC.
- DACC/IACC outputs: ramREN or ramWEN=1, ramaddr={latched[31:2],2'b00}; ramstore = latched dstore on writes, else 0. The wait counter increments each cycle.
- DACC/IACC exit on ram_ready=1 at an edge: capture ramload into the iload/dload register, go to RESP, and clear the wait counter.
- DACC/IACC timeout: wait counter == TIMEOUT with ram_ready=0 sends the state to ERR.
- RESP (exactly one cycle): ihit or dhit=1 for the completing source, RAM enables 0, no arbitration. Next state is IDLE.
  - This lets the requester advance PC or drop dREN before being re-arbitrated.
- Latency: request high in cycle 0, RAM enable in cycle 1, ram_ready in cycle k≥1, hit in cycle k+1. Minimum is 2 cycles.
- Requests that drop while in DACC/IACC do not cancel the access; the hit is still issued.
- iload/dload hold their value outside hit cycles.
- ERR is terminal until reset: mem_err=1, RAM enables 0, no hits.
- halt: halt_seen sets on any edge with halt=1 and is sticky.
  - After halt_seen, no new fetches are started.
  - Data accesses are still served, including one already in flight.
  - halted=1 once halt_seen=1 and the state is IDLE.
- Counters: icount/dcount increment at the edge entering RESP for the matching source and wrap modulo 2^CNT_W.
- Simultaneous iREN and dREN in IDLE: data wins; the fetch is served on the next IDLE pass if still requested.

Test Plan:
- iREN=1, iaddr=0x40, ram_ready returned 1 cycle after ramREN, ramload=0x8C220004 -> ramaddr=0x40, ihit in cycle 2 for one cycle, iload=0x8C220004, icount=1.
- iREN and dWEN high together, daddr=0x103, dstore=0xDEADBEEF -> write first with ramaddr=0x100 and ramWEN=1, dhit; then fetch and ihit; dcount=1, icount=1.
- Read with ram_ready delayed 5 cycles -> ramREN held 5 cycles, dhit exactly once, dload equals ramload; no hit during the wait.
- TIMEOUT=4, ram_ready held 0 -> ERR after 4 wait cycles, mem_err=1, enables 0, further requests ignored until nRST=0.
- halt=1 during an outstanding data read -> read completes with dhit, then halted=1, and iREN=1 produces no ramREN.
- nRST=0 during IACC -> next cycle ihit=0, ramREN=0, counters 0, state IDLE; fetch restarts after nRST=1.
